pipelined_subtractor: RTL

Parametrised, pipelined N-bit subtractor with borrow-in/borrow-out and a valid/ready streaming handshake. It splits a WIDTH-bit subtraction into STAGES equal slices, one slice per pipeline register stage, with the borrow carried stage to stage. Throughput is one operation per cycle. It replaces chained full-subtractor cells wherever a subtract sits in a clocked datapath and must meet timing at larger widths.

---
 rtl/pipelined_subtractor.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor with borrow chain, split into STAGES slices, valid/ready stream.
// Latency STAGES cycles; stalls the whole pipe when out_valid && !out_ready. Define SUB_SATURATE_EN to clamp underflow to 0.
module pipelined_subtractor #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_subtractor: illegal WIDTH/STAGES combination");
  end

  logic [STAGES-1:0]            vld_q, vld_d, brw_q, brw_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, dif_q, dif_d;
  logic [STAGES-1:0]            src_vld, src_brw;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_dif;
  logic [STAGES-1:0][SW:0]      slice_res;
  logic                         adv;

  // Whole pipe moves in lockstep; bubbles are never squeezed out.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_comb begin
    src_vld    = '0;
    src_brw    = '0;
    src_a      = '0;
    src_b      = '0;
    src_dif    = '0;
    src_vld[0] = in_valid;
    src_brw[0] = bin;
    src_a[0]   = a;
    src_b[0]   = b;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_brw[k] = brw_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_dif[k] = dif_q[k-1];
    end
  end

  // Extra top bit of each slice result is the borrow out of that slice.
  always_comb begin
    vld_d     = src_vld;
    brw_d     = '0;
    a_d       = src_a;
    b_d       = src_b;
    dif_d     = src_dif;
    slice_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_res[k] = {1'b0, src_a[k][k*SW +: SW]} - {1'b0, src_b[k][k*SW +: SW]}
                   - {{SW{1'b0}}, src_brw[k]};
      dif_d[k][k*SW +: SW] = slice_res[k][SW-1:0];
      brw_d[k]             = slice_res[k][SW];
    end
`ifdef SUB_SATURATE_EN
    if (brw_d[STAGES-1]) begin
      dif_d[STAGES-1] = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      brw_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dif_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      brw_q <= brw_d;
      a_q   <= a_d;
      b_q   <= b_d;
      dif_q <= dif_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign diff      = dif_q[STAGES-1];
  assign bout      = brw_q[STAGES-1];

  // Operands riding in the last stage have no consumer.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule
